// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Purpose  : Direction encoding and shared constants for the snake game blocks.
// Revision : 1.0
// ============================================================================
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_CNT_W           = 20;
    localparam int NUM_BTN                 = 4;

    // Opposite directions differ only in bit 0 of the encoding.
    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    function automatic logic is_legal_turn(input dir_t cur, input dir_t cand);
        return (cand != cur) && (cand != opposite_dir(cur));
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : button_ctrl_if
// Purpose  : Raw button inputs and direction command outputs of button_ctrl.
// Revision : 1.0
// ============================================================================
interface button_ctrl_if;
    import snake_pkg::*;

    logic btn_up;
    logic btn_down;
    logic btn_left;
    logic btn_right;
    logic game_over;
    logic up;
    logic down;
    logic left;
    logic right;
    dir_t dir;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, game_over,
        input  up, down, left, right, dir
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, game_over,
        output up, down, left, right, dir
    );

endinterface
`default_nettype wire

// File: rtl/button_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module   : debounce
// Purpose  : 2-FF synchronizer, stability counter and press-edge detect for
//            one active-high push-button.
// Revision : 1.0
// ============================================================================
module debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  raw,
    output logic db,
    output logic press
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_db;
    logic             r_db_prev;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;

    assign w_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync    <= 2'b00;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync    <= {r_sync[0], raw};
            r_db_prev <= r_db;
            r_press   <= r_db & ~r_db_prev;
            // Any single agreeing cycle restarts the stability count.
            if (w_s == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_db  <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign db    = r_db;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_ctrl
// Purpose  : Debounces four buttons and issues legal one-cycle turn commands
//            plus the current heading to gameLogic.
// Revision : 1.0
// ============================================================================
module button_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  wire          clk,
    input  wire          reset,
    button_ctrl_if.slave bus
);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_db;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_event;

    // Bit index equals the direction encoding.
    assign w_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .raw   (w_raw[gi]),
                .db    (w_db[gi]),
                .press (w_press[gi])
            );
        end
    endgenerate

    // A press pulse always coincides with the debounced level being high.
    assign w_event = w_press & w_db;

    dir_t               r_dir;
    logic [NUM_BTN-1:0] r_pulse;
    dir_t               w_cand;
    logic               w_cand_valid;
    logic               w_accept;
    dir_t               w_dir_next;
    logic [NUM_BTN-1:0] w_pulse_next;

    // Highest-priority event wins; the rest are dropped for this cycle.
    always_comb begin
        w_cand       = DIR_RIGHT;
        w_cand_valid = 1'b0;
        w_accept     = 1'b0;
        w_dir_next   = r_dir;
        w_pulse_next = '0;
        if (w_event[DIR_UP]) begin
            w_cand       = DIR_UP;
            w_cand_valid = 1'b1;
        end else if (w_event[DIR_DOWN]) begin
            w_cand       = DIR_DOWN;
            w_cand_valid = 1'b1;
        end else if (w_event[DIR_LEFT]) begin
            w_cand       = DIR_LEFT;
            w_cand_valid = 1'b1;
        end else if (w_event[DIR_RIGHT]) begin
            w_cand       = DIR_RIGHT;
            w_cand_valid = 1'b1;
        end
        w_accept = w_cand_valid && !bus.game_over && is_legal_turn(r_dir, w_cand);
        if (w_accept) begin
            w_dir_next           = w_cand;
            w_pulse_next[w_cand] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dir   <= DIR_RIGHT;
            r_pulse <= '0;
        end else begin
            r_dir   <= w_dir_next;
            r_pulse <= w_pulse_next;
        end
    end

    assign bus.up    = r_pulse[DIR_UP];
    assign bus.down  = r_pulse[DIR_DOWN];
    assign bus.left  = r_pulse[DIR_LEFT];
    assign bus.right = r_pulse[DIR_RIGHT];
    assign bus.dir   = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_ctrl
// Purpose  : Self-checking bench for button_ctrl with DEBOUNCE_CYCLES = 4.
// Revision : 1.0
// ============================================================================
module tb_button_ctrl;

    localparam int LAT = 8;  // negedge index of the pulse relative to the drive negedge

    typedef struct {
        logic [3:0]  btn;        // {right, left, down, up}
        int          hold;
        logic        go;
        logic [3:0]  exp_pulse;
        logic [1:0]  exp_dir;
        string       name;
    } vec_t;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] dir;
        int         cyc;
        string      name;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    exp_t q[$];
    vec_t vecs[16];

    button_ctrl_if bus();

    button_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] m);
        bus.btn_up    = m[0];
        bus.btn_down  = m[1];
        bus.btn_left  = m[2];
        bus.btn_right = m[3];
    endtask

    // Advance to the next negedge and score any pulse seen there.
    task automatic tick();
        logic [3:0] p;
        exp_t       e;
        @(negedge clk);
        p = {bus.right, bus.left, bus.down, bus.up};
        if (p != 4'b0000) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d expected none", p, cyc);
            end else begin
                e = q.pop_front();
                chk({e.name, "_pulse"}, int'(p), int'(e.mask));
                chk({e.name, "_cycle"}, cyc, e.cyc);
                chk({e.name, "_dir_at_pulse"}, int'(bus.dir), int'(e.dir));
            end
        end
    endtask

    task automatic check_end(input logic [1:0] exp_dir, input string name);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_pulse: got none expected %0d pulse(s)", name, q.size());
        end
        q.delete();
        chk({name, "_dir"}, int'(bus.dir), int'(exp_dir));
    endtask

    task automatic run_vec(input vec_t v);
        tick();
        bus.game_over = v.go;
        set_btn(v.btn);
        if (v.exp_pulse != 4'b0000)
            q.push_back('{mask: v.exp_pulse, dir: v.exp_dir, cyc: cyc + LAT, name: v.name});
        repeat (v.hold) tick();
        set_btn(4'b0000);
        repeat (12) tick();
        bus.game_over = 1'b0;
        check_end(v.exp_dir, v.name);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{4'b0000, 20, 1'b0, 4'b0000, 2'd3, "idle"};
        vecs[1]  = '{4'b0001,  3, 1'b0, 4'b0000, 2'd3, "short3"};
        vecs[2]  = '{4'b0001, 10, 1'b0, 4'b0001, 2'd0, "up_hold"};
        vecs[3]  = '{4'b0010,  6, 1'b0, 4'b0000, 2'd0, "rev_down"};
        vecs[4]  = '{4'b0001,  6, 1'b0, 4'b0000, 2'd0, "rep_up"};
        vecs[5]  = '{4'b0100,  6, 1'b0, 4'b0100, 2'd2, "left"};
        vecs[6]  = '{4'b1000,  6, 1'b0, 4'b0000, 2'd2, "rev_right"};
        vecs[7]  = '{4'b0010,  6, 1'b0, 4'b0010, 2'd1, "down"};
        vecs[8]  = '{4'b0001,  6, 1'b0, 4'b0000, 2'd1, "rev_up"};
        vecs[9]  = '{4'b1000,  6, 1'b0, 4'b1000, 2'd3, "right"};
        vecs[10] = '{4'b0100,  6, 1'b0, 4'b0000, 2'd3, "rev_left"};
        vecs[11] = '{4'b0101,  6, 1'b0, 4'b0001, 2'd0, "up_left_same"};
        vecs[12] = '{4'b0100,  6, 1'b0, 4'b0100, 2'd2, "left_after"};
        vecs[13] = '{4'b0001,  8, 1'b1, 4'b0000, 2'd2, "game_over"};
        vecs[14] = '{4'b0001,  4, 1'b0, 4'b0001, 2'd0, "exact4"};
        vecs[15] = '{4'b1010,  6, 1'b0, 4'b0000, 2'd0, "down_right_same"};

        reset         = 1'b0;
        bus.game_over = 1'b0;
        set_btn(4'b0000);
        repeat (3) tick();
        chk("reset_pulses", int'({bus.right, bus.left, bus.down, bus.up}), 0);
        chk("reset_dir", int'(bus.dir), 3);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // 1-cycle low glitch inside a 6-cycle press of a legal direction
        begin
            logic [5:0] pat;
            pat = 6'b111011;
            for (int i = 0; i < 6; i++) begin
                tick();
                set_btn(pat[i] ? 4'b0100 : 4'b0000);
            end
            tick();
            set_btn(4'b0000);
            repeat (12) tick();
            check_end(2'd0, "glitch");
        end

        // Press lands under game_over; dropping game_over while held must not replay it
        tick();
        bus.game_over = 1'b1;
        set_btn(4'b1000);
        repeat (9) tick();
        bus.game_over = 1'b0;
        repeat (6) tick();
        set_btn(4'b0000);
        repeat (12) tick();
        check_end(2'd0, "go_release");

        // Reset mid-count with the button held: full debounce after release
        tick();
        set_btn(4'b0001);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("midreset_dir", int'(bus.dir), 3);
        chk("midreset_pulses", int'({bus.right, bus.left, bus.down, bus.up}), 0);
        reset = 1'b1;
        q.push_back('{mask: 4'b0001, dir: 2'd0, cyc: cyc + LAT, name: "post_reset_up"});
        repeat (10) tick();
        set_btn(4'b0000);
        repeat (12) tick();
        check_end(2'd0, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
